// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for 4, 6 or 8 column states.
// The byte permutation sits in front of stage 0; later stages form an elastic valid/ready pipeline.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [32*NB-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic             out_inv,
  output logic [2:0]       occupancy
);
  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..4");
  end

  // Byte k = 4*c + r lives at the k-th byte from the MSB end; 256-bit blocks use row offsets 0,1,3,4.
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] o;
    int s;
    int src;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        s   = (r == 0) ? 0 : ((NB == 8 && r >= 2) ? r + 1 : r);
        src = inv ? (c - s + NB) % NB : (c + s) % NB;
        o[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] inv_q, inv_d;
  logic [STAGES-1:0] load;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [2:0]        occ_q, occ_d;
  logic              accept, emit;

  // Ready chain: a stage loads when empty or when its successor drains it this cycle.
  always_comb begin
    load = '0;
    load[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      load[i] = !vld_q[i] || load[i+1];
    end
  end

  assign in_ready = load[0] && rst_n;
  assign accept   = in_valid && in_ready;
  assign emit     = vld_q[STAGES-1] && out_ready;

  always_comb begin
    vld_d = vld_q;
    inv_d = inv_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
    end
    // Stage 0 boundary: permuted input enters here
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        inv_d[0]  = in_inv;
        data_d[0] = shift_rows(in_data, in_inv);
      end
    end
    // Stages 1..STAGES-1: plain pass-through
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          inv_d[i]  = inv_q[i-1];
          data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, emit})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      inv_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      inv_q <= inv_d;
      occ_q <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe across NB=4/6/8 and STAGES=1/2/3 instances.
// One shared stimulus bus is steered to the instance selected by sel.
module tb_shift_rows_pipe;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_inv, out_ready;
  logic [255:0] in_data;
  int           sel;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  // sel 0: NB4/S1, 1: NB6/S2, 2: NB8/S1, 3: NB4/S3
  logic         iv0, iv1, iv2, iv3;
  logic         ir0, ir1, ir2, ir3;
  logic         ov0, ov1, ov2, ov3;
  logic         oi0, oi1, oi2, oi3;
  logic [2:0]   oc0, oc1, oc2, oc3;
  logic [127:0] od0, od3;
  logic [191:0] od1;
  logic [255:0] od2;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);
  assign iv3 = in_valid && (sel == 3);

  shift_rows_pipe #(.NB(4), .STAGES(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
    .in_inv(in_inv), .in_data(in_data[127:0]), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_inv(oi0), .occupancy(oc0));
  shift_rows_pipe #(.NB(6), .STAGES(2)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_inv(in_inv), .in_data(in_data[191:0]), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_inv(oi1), .occupancy(oc1));
  shift_rows_pipe #(.NB(8), .STAGES(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .in_inv(in_inv), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_inv(oi2), .occupancy(oc2));
  shift_rows_pipe #(.NB(4), .STAGES(3)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .in_inv(in_inv), .in_data(in_data[127:0]), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .out_inv(oi3), .occupancy(oc3));

  logic         cur_in_ready, cur_out_valid, cur_out_inv;
  logic [255:0] cur_out_data;
  logic [2:0]   cur_occ;

  always_comb begin
    cur_in_ready = ir0; cur_out_valid = ov0; cur_out_inv = oi0; cur_occ = oc0;
    cur_out_data = {128'h0, od0};
    case (sel)
      1: begin cur_in_ready = ir1; cur_out_valid = ov1; cur_out_inv = oi1; cur_occ = oc1;
               cur_out_data = {64'h0, od1}; end
      2: begin cur_in_ready = ir2; cur_out_valid = ov2; cur_out_inv = oi2; cur_occ = oc2;
               cur_out_data = od2; end
      3: begin cur_in_ready = ir3; cur_out_valid = ov3; cur_out_inv = oi3; cur_occ = oc3;
               cur_out_data = {128'h0, od3}; end
      default: ;
    endcase
  end

  function automatic int nb_of(input int s);
    return (s == 1) ? 6 : ((s == 2) ? 8 : 4);
  endfunction

  // Reference model on right-aligned blocks; the inverse scatters instead of gathering.
  function automatic logic [255:0] model(input logic [255:0] x, input logic inv, input int nb);
    logic [7:0]   st [4][8];
    logic [7:0]   o  [4][8];
    logic [255:0] y;
    int           sh;
    y = '0;
    for (int c = 0; c < 8; c++) for (int r = 0; r < 4; r++) begin st[r][c] = 8'h0; o[r][c] = 8'h0; end
    for (int c = 0; c < nb; c++) for (int r = 0; r < 4; r++) st[r][c] = x[nb*32-1-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++) begin
      sh = (r == 0) ? 0 : ((nb == 8 && r > 1) ? r + 1 : r);
      for (int c = 0; c < nb; c++) begin
        if (!inv) o[r][c] = st[r][(c + sh) % nb];
        else      o[r][(c + sh) % nb] = st[r][c];
      end
    end
    for (int c = 0; c < nb; c++) for (int r = 0; r < 4; r++) y[nb*32-1-8*(4*c+r) -: 8] = o[r][c];
    return y;
  endfunction

  function automatic logic [255:0] rand_blk(input int nb);
    logic [255:0] b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (nb < 8) b = b & ((256'h1 << (nb * 32)) - 256'h1);
    return b;
  endfunction

  logic [255:0] src_q[$];
  logic         src_inv_q[$];
  logic [255:0] ref_q[$];
  logic [255:0] sb_data[$];
  logic         sb_inv[$];
  logic [255:0] cap_q[$];

  // Streams src_q into instance s; expected values are queued on accept and popped on emit.
  task automatic run_stream(input int s, input bit use_ref, input int rdy_pct, input int vld_pct,
                            input string name);
    int           acc = 0;
    int           emi = 0;
    int           n;
    int           budget;
    logic [255:0] exp_d;
    logic         exp_i;
    n = src_q.size();
    budget = n * 40 + 100;
    sel = s;
    sb_data.delete(); sb_inv.delete(); cap_q.delete();
    while ((acc < n || sb_data.size() > 0) && budget > 0) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = (acc < n) && ($urandom_range(99) < vld_pct);
      in_data   = (acc < n) ? src_q[acc] : '0;
      in_inv    = (acc < n) ? src_inv_q[acc] : 1'b0;
      #1;
      checks++;
      if (cur_occ !== 3'(acc - emi)) begin
        errors++;
        $display("FAIL %s_occupancy: got %0d exp %0d", name, cur_occ, acc - emi);
      end
      if (cur_out_valid && out_ready) begin
        checks++;
        if (sb_data.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_output: got %h with empty scoreboard", name, cur_out_data);
        end else begin
          exp_d = sb_data.pop_front();
          exp_i = sb_inv.pop_front();
          if (cur_out_data !== exp_d || cur_out_inv !== exp_i) begin
            errors++;
            $display("FAIL %s_data: got %h inv %b exp %h inv %b", name, cur_out_data, cur_out_inv,
                     exp_d, exp_i);
          end
        end
        cap_q.push_back(cur_out_data);
        emi++;
      end
      if (in_valid && cur_in_ready) begin
        sb_data.push_back(use_ref ? ref_q[acc] : model(src_q[acc], src_inv_q[acc], nb_of(s)));
        sb_inv.push_back(src_inv_q[acc]);
        acc++;
      end
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d emitted exp %0d", name, emi, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      checks++;
      if (cur_out_valid !== 1'b0 || cur_occ !== 3'd0 || cur_out_data !== '0 || cur_out_inv !== 1'b0
          || cur_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_state_%0d: got v=%b occ=%0d inv=%b rdy=%b data=%h exp all zero", s,
                 cur_out_valid, cur_occ, cur_out_inv, cur_in_ready, cur_out_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      checks++;
      if (cur_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready_%0d: got %b exp 1", s, cur_in_ready);
      end
    end
  endtask

  task automatic test_fips();
    src_q = '{256'hd42711aee0bf98f1b8b45de51e415230};
    src_inv_q = '{1'b0};
    ref_q = '{256'hd4bf5d30e0b452aeb84111f11e2798e5};
    run_stream(0, 1'b1, 100, 100, "fips_fwd");
    src_q = '{256'hd4bf5d30e0b452aeb84111f11e2798e5};
    src_inv_q = '{1'b1};
    ref_q = '{256'hd42711aee0bf98f1b8b45de51e415230};
    run_stream(0, 1'b1, 100, 100, "fips_inv");
  endtask

  task automatic test_nb8_ascending();
    logic [255:0] b;
    logic [255:0] last;
    for (int k = 0; k < 32; k++) b[255-8*k -: 8] = 8'(k);
    src_q = '{b};
    src_inv_q = '{1'b0};
    run_stream(2, 1'b0, 100, 100, "nb8_fwd");
    checks++;
    last = (cap_q.size() > 0) ? cap_q[0] : '0;
    if (last[255:224] !== 32'h00050e13) begin
      errors++;
      $display("FAIL nb8_col0: got %h exp 00050e13", last[255:224]);
    end
  endtask

  task automatic test_roundtrip(input int s);
    logic [255:0] orig[$];
    src_q.delete(); src_inv_q.delete(); orig.delete();
    for (int i = 0; i < 1000; i++) begin
      src_q.push_back(rand_blk(nb_of(s)));
      src_inv_q.push_back(1'b0);
    end
    orig = src_q;
    run_stream(s, 1'b0, 100, 100, "roundtrip_fwd");
    src_q = cap_q;
    src_inv_q.delete();
    for (int i = 0; i < src_q.size(); i++) src_inv_q.push_back(1'b1);
    ref_q = orig;
    run_stream(s, 1'b1, 100, 100, "roundtrip_inv");
  endtask

  task automatic test_stall();
    logic [255:0] blk[5];
    int           acc = 0;
    sel = 3;
    for (int i = 0; i < 5; i++) blk[i] = rand_blk(4);
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inv = 1'b0; in_data = blk[acc];
      #1;
      if (cyc >= 3) begin
        checks++;
        if (cur_out_valid !== 1'b1 || cur_out_data !== model(blk[0], 1'b0, 4) || cur_out_inv !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h exp v=1 %h", cur_out_valid, cur_out_data,
                   model(blk[0], 1'b0, 4));
        end
      end
      if (cur_in_ready) acc++;
    end
    @(negedge clk);
    in_data = blk[acc];
    #1;
    checks++;
    if (acc != 3 || cur_in_ready !== 1'b0 || cur_occ !== 3'd3) begin
      errors++;
      $display("FAIL stall_full: got acc=%0d rdy=%b occ=%0d exp acc=3 rdy=0 occ=3", acc, cur_in_ready, cur_occ);
    end
    out_ready = 1'b1;
    #1;
    for (int e = 0; e < 5; e++) begin
      checks++;
      if (cur_out_valid !== 1'b1 || cur_out_data !== model(blk[e], 1'b0, 4)) begin
        errors++;
        $display("FAIL stall_drain_%0d: got v=%b %h exp v=1 %h", e, cur_out_valid, cur_out_data,
                 model(blk[e], 1'b0, 4));
      end
      if (in_valid && cur_in_ready) acc++;
      @(negedge clk);
      in_valid = (acc < 5);
      in_data  = blk[(acc < 5) ? acc : 0];
      #1;
    end
    checks++;
    if (cur_occ !== 3'd0 || cur_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: got occ=%0d v=%b exp occ=0 v=0", cur_occ, cur_out_valid);
    end
  endtask

  task automatic test_random_mixed();
    src_q.delete(); src_inv_q.delete();
    for (int i = 0; i < 300; i++) begin
      src_q.push_back(rand_blk(6));
      src_inv_q.push_back(1'(i % 2));
    end
    run_stream(1, 1'b0, 50, 60, "random_mixed");
  endtask

  task automatic test_reset_mid();
    sel = 1; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b1; in_inv = 1'b1; in_data = rand_blk(6);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (cur_occ !== 3'd2 || cur_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fill: got occ=%0d rdy=%b exp occ=2 rdy=0", cur_occ, cur_in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready_low: got %b exp 0", cur_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (cur_out_valid !== 1'b0 || cur_occ !== 3'd0 || cur_out_data !== '0 || cur_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: got v=%b occ=%0d rdy=%b data=%h exp v=0 occ=0 rdy=1 data=0",
               cur_out_valid, cur_occ, cur_in_ready, cur_out_data);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_nb8_ascending();
    test_roundtrip(0);
    test_roundtrip(1);
    test_roundtrip(2);
    test_stall();
    test_random_mixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit for the AES datapath and its wide-block Rijndael variants. It supports block widths of 128, 192 and 256 bits, selected by column count NB. Direction is chosen per transfer by a mode bit, so encryption and decryption rounds share one instance. Valid/ready handshakes sit on both sides, with a STAGES-deep elastic register pipeline that sustains one block per cycle.

Parameters:
NB, 4, state columns (4, 6 or 8); block width W = 32*NB; any other value is an elaboration error
STAGES, 1, pipeline register stages (1..4); any other value is an elaboration error

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream block valid
in_ready  output  1  unit accepts block this cycle
in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
in_data  input  W  state, column-major, byte k = 4*c + r, byte 0 at MSBs in_data[W-1 -: 8]
out_valid  output  1  output block valid
out_ready  input  1  downstream accepts
out_data  output  W  transformed state, same byte ordering
out_inv  output  1  in_inv of the block currently on out_data
occupancy  output  3  number of valid stages held (0..STAGES)

Behaviour:
- Row shift offsets s[r]: NB=4 and NB=6 use 0,1,2,3; NB=8 uses 0,1,3,4.
- Forward transform: out[r][c] = in[r][(c + s[r]) mod NB].
- Inverse transform: out[r][c] = in[r][(c - s[r] + NB) mod NB].
- Transform is combinational in front of stage 1. Stages 2..STAGES pass data through unchanged.
- Each stage holds {valid, inv, data}.
- Stage i loads when it is empty or stage i+1 takes its contents this cycle. The last stage's "take" is out_ready.
- in_ready = stage-1 load condition AND rst_n. The ready chain is combinational back to in_ready; there is no skid buffer.
- A transfer occurs on a cycle with valid & ready both high. There are no bubbles: with out_ready held high, throughput is 1 block/cycle.
- Latency: a block accepted at edge N appears with out_valid=1 after edge N+STAGES-1 and is visible in cycle N+STAGES.
- Stall: while out_valid=1 and out_ready=0, out_data and out_inv hold stable and the pipeline fills up to STAGES blocks. With the pipeline full, in_ready=0.
- Simultaneous accept and emit on a full pipeline: the whole pipeline advances and occupancy is unchanged.
- in_data and in_inv are don't-care when in_valid=0.
- Ordering: blocks leave in acceptance order. Mixed forward/inverse streams are allowed back-to-back with no penalty.
- occupancy increments on accept-only, decrements on emit-only, and is unchanged on both or neither.
- Reset: while rst_n=0, all stage valids clear at the edge and in_ready=0.
- Reset values: out_valid=0, out_data=0, out_inv=0, occupancy=0.
- Reset mid-operation drops all in-flight blocks. The first accept is possible in the first cycle with rst_n=1.

Test Plan:
- NB=4, STAGES=1, in_inv=0, in_data=d42711aee0bf98f1b8b45de51e415230 (FIPS-197 round 1) -> next cycle out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_inv=0.
- NB=4, in_inv=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_inv=1.
- NB=8, in_inv=0, bytes 00..1f ascending -> first column of out_data = 00 05 0e 13. A forward then inverse round-trip over 1000 random blocks returns the original block, for NB=4, 6 and 8.
- STAGES=3, out_ready=0, 5 back-to-back valid blocks offered:
  - 3 are accepted, then in_ready=0 and occupancy=3.
  - out_data holds block 0 unchanged while stalled.
  - Raising out_ready emits blocks 0..4 in order on consecutive cycles.
- STAGES=2, out_ready toggled randomly, in_valid random, alternating in_inv:
  - Scoreboard sees no loss, duplication or reordering.
  - Each out_inv matches its block.
  - occupancy always equals accepted minus emitted.
- Assert rst_n=0 for 1 cycle with occupancy=2 -> next cycle out_valid=0, occupancy=0, out_data=0. in_ready=0 during reset and =1 in the first cycle after release.
